// File: rtl/jpeg_pkg.sv
// Shared JPEG marker codes and parser state encoding for the byte-stream front end.
// Constants only: no latency, no flow control.
package jpeg_pkg;

  localparam logic [7:0] MK_FF      = 8'hFF;
  localparam logic [7:0] MK_SOI     = 8'hD8;
  localparam logic [7:0] MK_SOS     = 8'hDA;
  localparam logic [7:0] MK_EOI     = 8'hD9;
  localparam logic [7:0] MK_RST0    = 8'hD0;
  localparam logic [7:0] MK_RST7    = 8'hD7;
  localparam logic [7:0] BYTE_STUFF = 8'h00;

  typedef enum logic [2:0] {
    ST_SEARCH,
    ST_MARK,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_HDR,
    ST_START,
    ST_SCAN
  } parse_state_t;

endpackage

// File: rtl/ecs_bit_shifter.sv
// ECS destuffer + one-byte prefetch + MSB-first bit shifter; a byte reaches o_ecs_bit 2 cycles after acceptance.
// Backpressure: o_ready drops while the prefetch byte is held or after the closing marker until drained.
module ecs_bit_shifter
  import jpeg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic       i_sysclk,
  input  logic       i_arst,
  input  logic       i_clr,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  input  logic       i_re,
  output logic       o_scan_en,
  output logic       o_ecs_bit,
  output logic       o_mark_end
);

  logic [7:0]       sh_q;
  logic [7:0]       buf_q;
  logic             buf_vld_q;
  logic             pend_ff_q;
  logic             ended_q;
  logic [CNT_W-1:0] cnt_q;

  logic             shift;
  logic             load;
  logic             dat_vld;
  logic [7:0]       dat;
  logic             pend_nxt;
  logic             end_nxt;

  assign o_ready    = i_byte_en && !buf_vld_q && !ended_q;
  assign o_scan_en  = (cnt_q != '0);
  assign o_ecs_bit  = o_scan_en & sh_q[7];
  assign o_mark_end = ended_q && !o_scan_en && !buf_vld_q;

  assign shift = i_re && o_scan_en;
  // Reload on the same edge the last bit leaves so back-to-back bytes have no bubble.
  assign load  = buf_vld_q && ((cnt_q == '0) || ((cnt_q == CNT_W'(1)) && shift));

  always_comb begin
    dat_vld  = 1'b0;
    dat      = i_byte;
    pend_nxt = pend_ff_q;
    end_nxt  = 1'b0;
    if (o_ready) begin
      if (pend_ff_q) begin
        if (i_byte == BYTE_STUFF) begin
          dat_vld  = 1'b1;
          dat      = MK_FF;
          pend_nxt = 1'b0;
        end else if (i_byte != MK_FF) begin
          pend_nxt = 1'b0;
          end_nxt  = 1'b1;
        end
      end else if (i_byte == MK_FF) begin
        pend_nxt = 1'b1;
      end else begin
        dat_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      sh_q      <= '0;
      buf_q     <= '0;
      buf_vld_q <= 1'b0;
      pend_ff_q <= 1'b0;
      ended_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (load) begin
        sh_q  <= buf_q;
        cnt_q <= CNT_W'(8);
      end else if (shift) begin
        sh_q  <= {sh_q[6:0], 1'b0};
        cnt_q <= cnt_q - CNT_W'(1);
      end

      if (dat_vld) begin
        buf_q     <= dat;
        buf_vld_q <= 1'b1;
      end else if (load) begin
        buf_vld_q <= 1'b0;
      end

      if (i_clr) begin
        pend_ff_q <= 1'b0;
        ended_q   <= 1'b0;
      end else begin
        pend_ff_q <= pend_nxt;
        if (end_nxt) ended_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sos_parser.sv
// JPEG front end: finds FFDA, skips the SOS header by its length, then streams destuffed ECS bits MSB-first.
// o_start one cycle after the last header byte; o_ready is combinational and stalls only inside the scan.
module sos_parser
  import jpeg_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic       i_sysclk,
  input  logic       i_arst,
  input  logic       i_byte_en,
  input  logic [7:0] i_byte,
  output logic       o_ready,
  input  logic       i_re,
  output logic       o_start,
  output logic       o_scan_en,
  output logic       o_ecs_bit
);

  parse_state_t state_q;
  logic [7:0]   len_hi_q;
  logic [15:0]  hdr_cnt_q;
  logic         start_q;

  logic         sh_en;
  logic         sh_rdy;
  logic         sh_end;
  logic         take;
  logic [15:0]  ls;

  assign sh_en   = i_byte_en && (state_q == ST_SCAN);
  assign ls      = {len_hi_q, i_byte};
  assign o_start = start_q;

  // Outputs are forced low the instant reset asserts, not at the next edge.
  assign o_ready = !i_arst && ((state_q == ST_SCAN) ? sh_rdy
                                                    : (i_byte_en && (state_q != ST_START)));
  assign take    = o_ready && (state_q != ST_SCAN);

  ecs_bit_shifter #(.CNT_W(CNT_W)) u_shifter (
    .i_sysclk  (i_sysclk),
    .i_arst    (i_arst),
    .i_clr     (start_q),
    .i_byte_en (sh_en),
    .i_byte    (i_byte),
    .o_ready   (sh_rdy),
    .i_re      (i_re),
    .o_scan_en (o_scan_en),
    .o_ecs_bit (o_ecs_bit),
    .o_mark_end(sh_end)
  );

  always_ff @(posedge i_sysclk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= ST_SEARCH;
      len_hi_q  <= '0;
      hdr_cnt_q <= '0;
      start_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_SEARCH: if (take && i_byte == MK_FF) state_q <= ST_MARK;
        ST_MARK: if (take) begin
          if (i_byte == MK_SOS)     state_q <= ST_LEN_HI;
          else if (i_byte != MK_FF) state_q <= ST_SEARCH;
        end
        ST_LEN_HI: if (take) begin
          len_hi_q <= i_byte;
          state_q  <= ST_LEN_LO;
        end
        ST_LEN_LO: if (take) begin
          // A length of 2 (or a malformed smaller one) means no header payload.
          if (ls <= 16'd2) begin
            state_q <= ST_START;
            start_q <= 1'b1;
          end else begin
            hdr_cnt_q <= ls - 16'd2;
            state_q   <= ST_HDR;
          end
        end
        ST_HDR: if (take) begin
          if (hdr_cnt_q == 16'd1) begin
            state_q <= ST_START;
            start_q <= 1'b1;
          end
          hdr_cnt_q <= hdr_cnt_q - 16'd1;
        end
        ST_START: state_q <= ST_SCAN;
        ST_SCAN:  if (sh_end) state_q <= ST_SEARCH;
        default:  state_q <= ST_SEARCH;
      endcase
    end
  end

endmodule

// File: tb/tb_sos_parser.sv
// Scoreboard bench for sos_parser: expected ECS bits are queued when the stream is loaded and popped as bits are taken.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_sos_parser;

  logic       r_sysclk = 1'b0;
  logic       r_arst;
  logic       byte_en;
  logic [7:0] byte_dat;
  logic       ready;
  logic       re;
  logic       start;
  logic       scan_en;
  logic       ecs_bit;

  logic [7:0] src_q[$];
  bit         exp_q[$];
  int         take_cyc[$];
  int n_cmp = 0, n_err = 0;
  int cyc = 0, starts = 0, start_cyc = 0;
  int bubbles = 0, seen_first = 0, stalls = 0;
  int starve = 0, starve_after = -1, taken = 0;
  int re_mode = 0, re_ph = 0;
  int ready_err = 0, idle_bit_err = 0;
  bit was_scan;

  always #5 r_sysclk = ~r_sysclk;

  sos_parser #(.CNT_W(4)) dut (
    .i_sysclk (r_sysclk),
    .i_arst   (r_arst),
    .i_byte_en(byte_en),
    .i_byte   (byte_dat),
    .o_ready  (ready),
    .i_re     (re),
    .o_start  (start),
    .o_scan_en(scan_en),
    .o_ecs_bit(ecs_bit)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic new_test(input int mode);
    starts = 0; bubbles = 0; seen_first = 0; stalls = 0;
    take_cyc.delete(); taken = 0; starve_after = -1; starve = 0;
    re_mode = mode; re_ph = 0;
  endtask

  task automatic step();
    bit tb;
    bit tbit;
    @(negedge r_sysclk);
    cyc++;
    if (start) begin starts++; start_cyc = cyc; end
    if (ready && !byte_en) ready_err++;
    if (!scan_en && ecs_bit) idle_bit_err++;
    if (byte_en && !ready && scan_en) stalls++;
    tb   = byte_en && ready;
    tbit = scan_en && re;
    if (tbit) begin
      if (exp_q.size() == 0) chk("spurious_bit", 1, 0);
      else chk("ecs_bit", int'(ecs_bit), int'(exp_q.pop_front()));
      seen_first = 1;
    end else if (seen_first != 0 && !scan_en && exp_q.size() > 0) begin
      bubbles++;
    end
    if (tb) take_cyc.push_back(cyc);
    @(posedge r_sysclk);
    #1;
    if (tb) begin
      void'(src_q.pop_front());
      taken++;
      if (taken == starve_after) starve = 20;
    end
    if (starve > 0) begin
      byte_en = 1'b0;
      starve--;
    end else begin
      byte_en = (src_q.size() > 0);
    end
    byte_dat = (src_q.size() > 0) ? src_q[0] : 8'h00;
    re = (re_mode == 0) ? 1'b1 : (re_ph == 0);
    re_ph = (re_ph + 1) % 3;
  endtask

  task automatic run_drain(input string tag, input int max);
    int n = 0;
    int quiet = 0;
    while (quiet < 4 && n < max) begin
      step();
      n++;
      if (src_q.size() == 0 && exp_q.size() == 0 && !scan_en) quiet++;
      else quiet = 0;
    end
    chk({tag, "_drained"}, int'(quiet >= 4), 1);
  endtask

  initial begin
    r_arst = 1'b1; byte_en = 1'b1; byte_dat = 8'hFF; re = 1'b0;
    #3;
    chk("rst_ready", int'(ready), 0);
    chk("rst_start", int'(start), 0);
    chk("rst_scan_en", int'(scan_en), 0);
    chk("rst_ecs_bit", int'(ecs_bit), 0);
    repeat (2) @(posedge r_sysclk);
    #1;
    r_arst = 1'b0; byte_en = 1'b0;

    // Header parse followed by stuffed ECS ending in EOI
    new_test(0);
    src_q = '{8'hFF, 8'hD8, 8'hFF, 8'hDA, 8'h00, 8'h0C, 8'h03, 8'h01, 8'h00, 8'h02,
              8'h11, 8'h03, 8'h11, 8'h00, 8'h3F, 8'h00,
              8'hA5, 8'hFF, 8'h00, 8'h3C, 8'hFF, 8'hD9};
    push_bits(8'hA5); push_bits(8'hFF); push_bits(8'h3C);
    run_drain("stuff", 300);
    chk("hdr_starts", starts, 1);
    chk("hdr_rate", take_cyc.size() > 15 ? take_cyc[15] - take_cyc[0] : -1, 15);
    chk("start_lat", take_cyc.size() > 15 ? start_cyc - take_cyc[15] : -1, 1);
    chk("stuff_bubbles", bubbles, 0);
    chk("stuff_taken", taken, 22);

    // Backpressure on the bit side, zero-length header
    new_test(1);
    src_q = '{8'hFF, 8'hDA, 8'h00, 8'h02, 8'hA5, 8'hFF, 8'h00, 8'h3C, 8'hFF, 8'hD9};
    push_bits(8'hA5); push_bits(8'hFF); push_bits(8'h3C);
    run_drain("bp", 600);
    chk("bp_starts", starts, 1);
    chk("bp_stalled", int'(stalls > 0), 1);
    chk("bp_taken", taken, 10);

    // APP0 alone must not start a scan
    new_test(0);
    src_q = '{8'hFF, 8'hE0, 8'h00, 8'h10, 8'h4A, 8'h46, 8'h49, 8'h46, 8'h00, 8'h01,
              8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h00};
    run_drain("app0", 200);
    chk("app0_starts", starts, 0);

    // Fill FFs before SOS, scan closed by RST0
    new_test(0);
    src_q = '{8'hFF, 8'hFF, 8'hFF, 8'hDA, 8'h00, 8'h04, 8'h11, 8'h22,
              8'h12, 8'h34, 8'hFF, 8'hD0};
    push_bits(8'h12); push_bits(8'h34);
    run_drain("fill", 200);
    chk("fill_starts", starts, 1);

    // Source starvation mid-ECS
    new_test(0);
    src_q = '{8'hFF, 8'hDA, 8'h00, 8'h03, 8'h77, 8'hC3, 8'h5A, 8'h96, 8'h0F, 8'hFF, 8'hD9};
    push_bits(8'hC3); push_bits(8'h5A); push_bits(8'h96); push_bits(8'h0F);
    starve_after = 7;
    run_drain("starve", 300);
    chk("starve_starts", starts, 1);
    chk("starve_dropped", int'(bubbles > 0), 1);

    // Asynchronous reset mid-scan, then a fresh stream
    new_test(0);
    src_q = '{8'hFF, 8'hDA, 8'h00, 8'h02, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA};
    for (int i = 0; i < 6; i++) push_bits(i % 2 == 0 ? 8'h55 : 8'hAA);
    for (int n = 0; n < 300 && exp_q.size() > 36; n++) step();
    was_scan = scan_en;
    chk("rst_midscan", int'(was_scan), 1);
    byte_en = 1'b1;
    r_arst  = 1'b1;
    #1;
    chk("arst_ready", int'(ready), 0);
    chk("arst_start", int'(start), 0);
    chk("arst_scan_en", int'(scan_en), 0);
    chk("arst_ecs_bit", int'(ecs_bit), 0);
    src_q.delete();
    exp_q.delete();
    byte_en = 1'b0;
    repeat (2) @(posedge r_sysclk);
    #1;
    r_arst = 1'b0;
    new_test(0);
    src_q = '{8'hFF, 8'hDA, 8'h00, 8'h02, 8'h81, 8'hFF, 8'hD9};
    push_bits(8'h81);
    run_drain("post_rst", 200);
    chk("post_rst_starts", starts, 1);

    chk("ready_without_en", ready_err, 0);
    chk("bit_while_idle", idle_bit_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sos_parser.md
Name: sos_parser

Overview:
- Byte-stream front end of the JPEG decoder.
- Hunts the incoming JPEG byte stream for the Start-Of-Scan marker (FFDA) and skips the SOS header.
- Removes byte stuffing from the entropy-coded segment (ECS) and serialises it MSB-first, one bit per read, to the Huffman decoder.
- Sits between the byte source (file/flash reader) and the bit-level entropy decoder.

Parameters:
- CNT_W, 4: width of the internal bit counter (counts 0..8; must be ≥4).

Ports:
- i_sysclk  in  1  system clock, all logic on rising edge
- i_arst  in  1  reset; asynchronous, active-high
- i_byte_en  in  1  i_byte holds a valid stream byte
- i_byte  in  8  current stream byte
- o_ready  out  1  byte on i_byte is accepted at this rising edge; source advances next cycle
- i_re  in  1  consumer takes the bit on o_ecs_bit at this edge
- o_start  out  1  one-cycle pulse: SOS header done, scan begins
- o_scan_en  out  1  o_ecs_bit holds a valid ECS bit
- o_ecs_bit  out  1  current ECS bit, MSB of current data byte first

Behaviour:
- Reset: i_arst is asynchronous and active-high. All state is cleared and the FSM enters SEARCH. o_ready, o_start, o_scan_en and o_ecs_bit are all 0.
- o_ready is combinational and never asserts without i_byte_en. A byte is consumed exactly when i_byte_en && o_ready at a rising edge.

FSM states:
- SEARCH: o_ready=i_byte_en, so every byte is consumed.
  - Byte FF → MARK.
  - Any other byte → stay in SEARCH.
- MARK:
  - Byte FF (fill) → stay in MARK.
  - Byte DA → LEN_HI.
  - Any other byte → SEARCH. Other markers are not skipped by length.
- LEN_HI, then LEN_LO: capture the 16-bit Ls. Remaining header count = Ls−2.
  - If the count is 0 → START.
  - Otherwise → HDR.
- HDR: consume and discard bytes, decrementing the count. When the last byte is accepted → START.
- START: o_start=1 for exactly one cycle, no byte consumed → SCAN.
- SCAN: ECS handling, detailed below.

ECS handling (SCAN):
- Byte FF is held as pending and the next byte is examined.
  - FF 00: deliver data byte FF; both bytes are consumed.
  - FF FF: still pending (fill).
  - FF followed by any other value (RSTn, EOI, …): that byte is consumed, the pending FF is dropped, bits already loaded are still delivered, then the FSM returns to SEARCH. Further scans are handled the same way.
- Data bytes go into an 8-bit shifter with a bit counter.
  - o_scan_en=1 whenever the counter is >0.
  - o_ecs_bit = shifter MSB.
  - i_re && o_scan_en: shift left 1 and decrement the counter.
  - i_re while o_scan_en=0 is ignored.
- A one-byte prefetch buffer holds the next data byte. With i_byte_en continuously high and i_re continuously high, o_scan_en must stay high without bubbles, including across stuffed FF00 pairs.
- o_ready deasserts in SCAN while the prefetch buffer is full and no stuffing lookahead is needed.
- No new SOS search starts until the shifter and buffer are empty.
- o_ecs_bit is 0 when o_scan_en=0.
- Reset mid-scan discards all buffered bits immediately.

Decomposition:
- Shared package jpeg_pkg holds:
  - marker constants: FF, SOI=D8, SOS=DA, EOI=D9, RST0..7=D0..D7;
  - the parser state enum.
- One natural sub-module: ecs_bit_shifter. It covers destuffing, prefetch buffer, shifter and bit counter (CNT_W), with signals o_scan_en, o_ecs_bit, i_re and marker-end.

Test Plan:
- Header parse:
  - Stimulus: FFD8, then FFDA 000C 03 01 00 02 11 03 11 00 3F 00, i_byte_en=1.
  - Response: exactly one o_start pulse, the cycle after the last 00 is accepted. o_ready consumes one byte per cycle before that.
- Stuffing:
  - Stimulus: after the above, ECS A5 FF 00 3C FF D9, i_re=1.
  - Response: bits 10100101 11111111 00111100, 24 bits, o_scan_en continuous. Then o_scan_en=0, FSM in SEARCH, D9 consumed.
- Backpressure:
  - Stimulus: i_re toggled 1 cycle on / 2 off.
  - Response: identical bit sequence; o_ready stalls while the buffer is full; no byte is lost or duplicated.
- Fill and false markers:
  - Stimulus: FF FF FF DA …, and FF E0 0010 … before SOS.
  - Response: fill FFs are ignored, so SOS is still detected. APP0 alone produces no o_start.
- Source starvation:
  - Stimulus: i_byte_en=0 for 20 cycles mid-ECS.
  - Response: o_scan_en drops once buffered bits run out and resumes with the next bit. No spurious bits.
- Reset:
  - Stimulus: i_arst pulsed mid-scan.
  - Response: all outputs 0 immediately (asynchronously). The next stream is parsed from SEARCH.
